throw_ctl: RTL and testbench

THROW_CTL -- requirements
Module: throw_ctl

---
 rtl/throw_pkg.sv | 19 +
 rtl/throw_ctl.sv | 123 ++++++++++++
 tb/tb_throw_ctl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/throw_pkg.sv
// Shared types and fixed-point constants for the projectile
// throw controller.
package throw_pkg;

  localparam int FRAC_BITS = 4;
  localparam int VW        = 10;
  localparam int PW        = 16;
  localparam int OW        = 12;

  localparam logic signed [VW-1:0] GRAVITY_DEF = 10'sd8;
  localparam logic [OW-1:0]        X_LIMIT_DEF = 12'd512;

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    DONE
  } state_t;

endpackage

// File: rtl/throw_ctl.sv
// Projectile flight controller: integrates a Q6.4 velocity
// into Q12.4 position once per video frame until landing.
module throw_ctl
  import throw_pkg::*;
#(
  parameter logic signed [VW-1:0] GRAVITY = GRAVITY_DEF,
  parameter logic [OW-1:0]        X_LIMIT = X_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic          throw_start,
  input  logic [OW-1:0] x_start,
  input  logic [VW-1:0] vx0,
  input  logic [VW-1:0] vy0,
  output logic [OW-1:0] x_pos,
  output logic [OW-1:0] y_pos,
  output logic          in_flight,
  output logic          landed
);

  function automatic logic signed [PW-1:0] sext(
    input logic signed [VW-1:0] v
  );
    return {{(PW-VW){v[VW-1]}}, v};
  endfunction

  // Clamp to the Q6.4 range instead of wrapping.
  function automatic logic signed [VW-1:0] sat_sub(
    input logic signed [VW-1:0] a,
    input logic signed [VW-1:0] b
  );
    logic [VW:0] d;
    d = {a[VW-1], a} - {b[VW-1], b};
    if (d[VW] != d[VW-1])
      return d[VW] ? {1'b1, {(VW-1){1'b0}}}
                   : {1'b0, {(VW-1){1'b1}}};
    return d[VW-1:0];
  endfunction

  state_t state, state_nx;

  logic signed [PW-1:0] x, x_nx;
  logic signed [PW-1:0] y, y_nx;
  logic signed [VW-1:0] vx, vx_nx;
  logic signed [VW-1:0] vy, vy_nx;

  logic signed [PW-1:0] x_step;
  logic signed [PW-1:0] y_step;
  logic [PW:0]          x_ext;
  logic [PW:0]          x_mag;
  logic [PW:0]          x_lim;
  logic                 hit_ground;
  logic                 out_of_bounds;

  always_comb begin
    x_step        = x + sext(vx);
    y_step        = y + sext(vy);
    x_ext         = {x_step[PW-1], x_step};
    x_mag         = x_step[PW-1] ? (~x_ext + 17'd1) : x_ext;
    x_lim         = {1'b0, X_LIMIT, {FRAC_BITS{1'b0}}};
    hit_ground    = (y_step <= 16'sd0);
    out_of_bounds = (x_mag > x_lim);
  end

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    vx_nx    = vx;
    vy_nx    = vy;
    unique case (state)
      IDLE: begin
        x_nx = {x_start, {FRAC_BITS{1'b0}}};
        y_nx = '0;
        if (throw_start) begin
          vx_nx    = vx0;
          vy_nx    = vy0;
          state_nx = FLIGHT;
        end
      end
      FLIGHT: begin
        if (frame_tick) begin
          x_nx  = x_step;
          vy_nx = sat_sub(vy, GRAVITY);
          if (hit_ground || out_of_bounds) begin
            // Ground hit and boundary exit share one path.
            y_nx     = y_step[PW-1] ? '0 : y_step;
            state_nx = DONE;
          end else begin
            y_nx = y_step;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      vx    <= '0;
      vy    <= '0;
      x_pos <= '0;
      y_pos <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      vx    <= vx_nx;
      vy    <= vy_nx;
      x_pos <= x[PW-1:FRAC_BITS];
      y_pos <= y[PW-1:FRAC_BITS];
    end
  end

  assign in_flight = (state == FLIGHT);
  assign landed    = (state == DONE);

endmodule

// File: tb/tb_throw_ctl.sv
// Scoreboard bench for throw_ctl: expected landings are queued
// by the stimulus and checked by a landed-pulse monitor.
module tb_throw_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        throw_start;
  logic        throw_start2;
  logic [11:0] x_start;
  logic [9:0]  vx0;
  logic [9:0]  vy0;
  logic [11:0] x_pos, y_pos;
  logic [11:0] x_pos2, y_pos2;
  logic        in_flight, landed;
  logic        in_flight2, landed2;

  always #5 clk = ~clk;

  throw_ctl dut (
    .clk(clk), .rst(rst),
    .frame_tick(frame_tick), .throw_start(throw_start),
    .x_start(x_start), .vx0(vx0), .vy0(vy0),
    .x_pos(x_pos), .y_pos(y_pos),
    .in_flight(in_flight), .landed(landed)
  );

  throw_ctl #(.GRAVITY(10'sd64)) dut_g (
    .clk(clk), .rst(rst),
    .frame_tick(frame_tick), .throw_start(throw_start2),
    .x_start(x_start), .vx0(vx0), .vy0(vy0),
    .x_pos(x_pos2), .y_pos(y_pos2),
    .in_flight(in_flight2), .landed(landed2)
  );

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    int          ticks;
  } exp_t;

  exp_t sb[$];
  int errors     = 0;
  int checks     = 0;
  int ticks      = 0;
  int land_cnt   = 0;
  int land2_cnt  = 0;
  int land2_tick = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (landed === 1'b1) begin
        land_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_landed: got 1 expected 0");
        end else begin
          e = sb.pop_front();
          chk("land_ticks", ticks, e.ticks);
          chk("land_in_flight", {31'd0, in_flight}, 0);
          @(negedge clk);
          chk("land_x", {20'd0, x_pos}, {20'd0, e.x});
          chk("land_y", {20'd0, y_pos}, {20'd0, e.y});
          chk("landed_width", {31'd0, landed}, 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (landed2) begin
      land2_cnt  <= land2_cnt + 1;
      land2_tick <= ticks;
    end
  end

  task automatic frame();
    @(negedge clk);
    frame_tick = 1'b1;
    ticks++;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic throw(input logic [11:0] xs,
                       input logic [9:0] vx,
                       input logic [9:0] vy,
                       input logic with_tick);
    @(negedge clk);
    x_start     = xs;
    vx0         = vx;
    vy0         = vy;
    throw_start = 1'b1;
    frame_tick  = with_tick;
    @(negedge clk);
    throw_start = 1'b0;
    frame_tick  = 1'b0;
    ticks       = 0;
  endtask

  task automatic fly(input int max);
    int start;
    start = land_cnt;
    for (int i = 0; i < max && land_cnt == start; i++)
      frame();
    if (land_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL fly_timeout: got no landing expected one");
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s2;
    rst          = 1'b1;
    frame_tick   = 1'b0;
    throw_start  = 1'b0;
    throw_start2 = 1'b0;
    x_start      = 12'd123;
    vx0          = 10'h0;
    vy0          = 10'h0;
    repeat (3) @(negedge clk);
    chk("rst_x", {20'd0, x_pos}, 0);
    chk("rst_y", {20'd0, y_pos}, 0);
    chk("rst_in_flight", {31'd0, in_flight}, 0);
    chk("rst_landed", {31'd0, landed}, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_track_x", {20'd0, x_pos}, 123);

    // Nominal arc: lands after 33 ticks at x=66.
    sb.push_back('{12'd66, 12'd0, 33});
    throw(12'd0, 10'h020, 10'h080, 1'b0);
    chk("a_in_flight", {31'd0, in_flight}, 1);
    frame(); chk("a_y1", {20'd0, y_pos}, 8);
    frame(); chk("a_y2", {20'd0, y_pos}, 15);
    frame(); chk("a_y3", {20'd0, y_pos}, 22);
    chk("a_x3", {20'd0, x_pos}, 6);
    fly(40);

    // Right-edge exit on tick 2 at x=520, height 31.
    sb.push_back('{12'd520, 12'd31, 2});
    throw(12'd500, 10'h0A0, 10'h100, 1'b0);
    fly(5);
    @(negedge clk);
    @(negedge clk);
    chk("b_idle_x", {20'd0, x_pos}, 500);
    chk("b_idle_y", {20'd0, y_pos}, 0);
    chk("b_in_flight", {31'd0, in_flight}, 0);

    // Throw coincident with tick, then ignored re-throw.
    sb.push_back('{12'd66, 12'd0, 33});
    throw(12'd0, 10'h020, 10'h080, 1'b1);
    repeat (3) @(negedge clk);
    chk("c_hold_y", {20'd0, y_pos}, 0);
    chk("c_hold_x", {20'd0, x_pos}, 0);
    chk("c_in_flight", {31'd0, in_flight}, 1);
    frame(); chk("c_y1", {20'd0, y_pos}, 8);
    @(negedge clk);
    x_start     = 12'd300;
    vx0         = 10'h1F0;
    vy0         = 10'h100;
    throw_start = 1'b1;
    @(negedge clk);
    throw_start = 1'b0;
    frame(); chk("c_y2", {20'd0, y_pos}, 15);
    chk("c_x2", {20'd0, x_pos}, 4);
    fly(40);

    // Zero vertical speed lands on the first tick.
    sb.push_back('{12'hF9D, 12'd0, 1});
    throw(12'hF9C, 10'h010, 10'h000, 1'b0);
    fly(3);

    // Heavy gravity: vy must clamp at -32.0 and still land.
    s2 = land2_cnt;
    @(negedge clk);
    x_start      = 12'd10;
    vx0          = 10'h000;
    vy0          = 10'h1F0;
    throw_start2 = 1'b1;
    @(negedge clk);
    throw_start2 = 1'b0;
    ticks        = 0;
    chk("g_in_flight", {31'd0, in_flight2}, 1);
    for (int i = 0; i < 30 && land2_cnt == s2; i++) begin
      frame();
      if (ticks == 16)
        chk("g_y16", {20'd0, y_pos2}, 16);
    end
    chk("g_landings", land2_cnt - s2, 1);
    chk("g_land_tick", land2_tick, 17);
    chk("g_x", {20'd0, x_pos2}, 10);
    chk("g_y", {20'd0, y_pos2}, 0);

    // Asynchronous reset between edges during a flight.
    throw(12'd0, 10'h020, 10'h080, 1'b0);
    frame(); frame(); frame();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("r_x", {20'd0, x_pos}, 0);
    chk("r_y", {20'd0, y_pos}, 0);
    chk("r_in_flight", {31'd0, in_flight}, 0);
    chk("r_landed", {31'd0, landed}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back('{12'd66, 12'd0, 33});
    throw(12'd0, 10'h020, 10'h080, 1'b0);
    frame(); chk("r2_y1", {20'd0, y_pos}, 8);
    fly(40);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
